// File: rtl/reg_writeback_ctrl.sv
// Register-file write-back controller: two result FIFOs (ALU, load), round-robin
// arbitration onto one registered write port, and the per-register pending scoreboard.
module reg_writeback_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_dest,
  output logic                     stall,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_addr,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     mem_ready,
  output logic                     write,
  output logic [ADDR_W-1:0]        write_back_address,
  output logic [DATA_W-1:0]        data_write,
  output logic [(1<<ADDR_W)-1:0]   pending,
  output logic                     err_spurious
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  // Index 0 is the ALU FIFO, index 1 the load FIFO.
  logic [ADDR_W-1:0] addr_q [2][FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_d [2][FIFO_DEPTH];
  logic [DATA_W-1:0] data_q [2][FIFO_DEPTH];
  logic [DATA_W-1:0] data_d [2][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [2], wr_ptr_d [2];
  logic [PTR_W-1:0]  rd_ptr_q [2], rd_ptr_d [2];
  logic [CNT_W-1:0]  cnt_q [2], cnt_d [2];

  logic [NREG-1:0]   pending_q, pending_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] wba_q, wba_d;
  logic [DATA_W-1:0] data_write_q, data_write_d;
  logic              err_q, err_d;
  src_e              last_grant_q, last_grant_d;

  logic              in_valid [2];
  logic [ADDR_W-1:0] in_addr [2];
  logic [DATA_W-1:0] in_data [2];
  logic              push [2];
  logic              pop [2];
  logic              not_empty [2];
  logic              pop_any;
  logic              pop_sel;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign stall              = issue_valid & pending_q[issue_dest];
  assign alu_ready          = (cnt_q[0] != CNT_FULL);
  assign mem_ready          = (cnt_q[1] != CNT_FULL);
  assign write              = write_q;
  assign write_back_address = wba_q;
  assign data_write         = data_write_q;
  assign pending            = pending_q;
  assign err_spurious       = err_q;

  // Arbitration works only from registered FIFO state; last_grant moves only on conflicts.
  always_comb begin
    in_valid[0] = alu_valid;
    in_addr[0]  = alu_addr;
    in_data[0]  = alu_data;
    in_valid[1] = mem_valid;
    in_addr[1]  = mem_addr;
    in_data[1]  = mem_data;
    for (int s = 0; s < 2; s++) begin
      not_empty[s] = (cnt_q[s] != '0);
      push[s]      = in_valid[s] && (cnt_q[s] != CNT_FULL);
    end
    last_grant_d = last_grant_q;
    pop_any      = not_empty[0] | not_empty[1];
    if (not_empty[0] && not_empty[1]) begin
      pop_sel      = (last_grant_q == SRC_ALU);
      last_grant_d = pop_sel ? SRC_MEM : SRC_ALU;
    end else begin
      pop_sel = not_empty[1];
    end
    pop[0]    = pop_any & ~pop_sel;
    pop[1]    = pop_any & pop_sel;
    head_addr = addr_q[pop_sel][rd_ptr_q[pop_sel]];
    head_data = data_q[pop_sel][rd_ptr_q[pop_sel]];
  end

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    for (int s = 0; s < 2; s++) begin
      wr_ptr_d[s] = wr_ptr_q[s];
      rd_ptr_d[s] = rd_ptr_q[s];
      cnt_d[s]    = cnt_q[s];
      if (push[s]) begin
        addr_d[s][wr_ptr_q[s]] = in_addr[s];
        data_d[s][wr_ptr_q[s]] = in_data[s];
        wr_ptr_d[s]            = wr_ptr_q[s] + PTR_W'(1);
      end
      if (pop[s]) rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(1);
      case ({push[s], pop[s]})
        2'b10:   cnt_d[s] = cnt_q[s] + CNT_W'(1);
        2'b01:   cnt_d[s] = cnt_q[s] - CNT_W'(1);
        default: cnt_d[s] = cnt_q[s];
      endcase
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (issue_valid && !stall) pending_d[issue_dest] = 1'b1;
    if (pop_any) pending_d[head_addr] = 1'b0;
    err_d        = err_q | (pop_any & ~pending_q[head_addr]);
    write_d      = pop_any;
    wba_d        = pop_any ? head_addr : wba_q;
    data_write_d = pop_any ? head_data : data_write_q;
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
      end
      pending_q    <= '0;
      write_q      <= 1'b0;
      wba_q        <= '0;
      data_write_q <= '0;
      err_q        <= 1'b0;
      last_grant_q <= SRC_ALU;
    end else begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr_q[s] <= wr_ptr_d[s];
        rd_ptr_q[s] <= rd_ptr_d[s];
        cnt_q[s]    <= cnt_d[s];
      end
      pending_q    <= pending_d;
      write_q      <= write_d;
      wba_q        <= wba_d;
      data_write_q <= data_write_d;
      err_q        <= err_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed bench for reg_writeback_ctrl: inputs driven 1 time unit after each rising
// edge, outputs checked there too, against hand-computed values.
module tb_reg_writeback_ctrl;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_dest;
  logic              stall;
  logic              alu_valid, mem_valid;
  logic [ADDR_W-1:0] alu_addr, mem_addr;
  logic [DATA_W-1:0] alu_data, mem_data;
  logic              alu_ready, mem_ready;
  logic              write;
  logic [ADDR_W-1:0] write_back_address;
  logic [DATA_W-1:0] data_write;
  logic [15:0]       pending;
  logic              err_spurious;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_writeback_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .stall(stall),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .write(write), .write_back_address(write_back_address), .data_write(data_write),
    .pending(pending), .err_spurious(err_spurious)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [ADDR_W-1:0] d);
    issue_valid = 1'b1;
    issue_dest  = d;
    step();
    issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; issue_valid = 0; issue_dest = 0;
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0;
    step(); step();
    rst = 1'b0;
    step();
    checks++; if (write !== 1'b0) begin failures++; $display("FAIL reset_write got %b exp 0", write); end
    checks++; if (write_back_address !== 4'h0) begin failures++; $display("FAIL reset_wba got %h exp 0", write_back_address); end
    checks++; if (data_write !== 32'h0) begin failures++; $display("FAIL reset_data got %h exp 0", data_write); end
    checks++; if (pending !== 16'h0) begin failures++; $display("FAIL reset_pending got %h exp 0", pending); end
    checks++; if (err_spurious !== 1'b0) begin failures++; $display("FAIL reset_err got %b exp 0", err_spurious); end
    checks++; if ({alu_ready, mem_ready} !== 2'b11) begin failures++; $display("FAIL reset_ready got %b exp 11", {alu_ready, mem_ready}); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got %b exp 0", stall); end
  endtask

  task automatic test_basic();
    do_issue(4'd3);
    checks++; if (pending !== 16'h0008) begin failures++; $display("FAIL basic_pending_set got %h exp 0008", pending); end
    alu_valid = 1; alu_addr = 4'd3; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 0;
    checks++; if (write !== 1'b0) begin failures++; $display("FAIL basic_no_early_write got %b exp 0", write); end
    step();
    checks++; if ({write, write_back_address, data_write} !== {1'b1, 4'd3, 32'hDEADBEEF}) begin
      failures++; $display("FAIL basic_write got w=%b a=%h d=%h exp w=1 a=3 d=deadbeef", write, write_back_address, data_write); end
    checks++; if (pending !== 16'h0) begin failures++; $display("FAIL basic_pending_clear got %h exp 0", pending); end
    checks++; if (err_spurious !== 1'b0) begin failures++; $display("FAIL basic_err got %b exp 0", err_spurious); end
    step();
    checks++; if ({write, data_write} !== {1'b0, 32'hDEADBEEF}) begin
      failures++; $display("FAIL basic_hold got w=%b d=%h exp w=0 d=deadbeef", write, data_write); end
  endtask

  task automatic test_stall();
    do_issue(4'd5);
    issue_valid = 1; issue_dest = 4'd5;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL stall_raised got %b exp 1", stall); end
    step();
    issue_valid = 0;
    checks++; if (pending !== 16'h0020) begin failures++; $display("FAIL stall_pending_hold got %h exp 0020", pending); end
    alu_valid = 1; alu_addr = 4'd5; alu_data = 32'h55;
    step();
    alu_valid = 0;
    step();
    checks++; if ({write, write_back_address, data_write} !== {1'b1, 4'd5, 32'h55}) begin
      failures++; $display("FAIL stall_wb got w=%b a=%h d=%h exp w=1 a=5 d=55", write, write_back_address, data_write); end
    issue_valid = 1; issue_dest = 4'd5;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL stall_released got %b exp 0", stall); end
    step();
    issue_valid = 0;
    checks++; if (pending !== 16'h0020) begin failures++; $display("FAIL stall_reissue got %h exp 0020", pending); end
    alu_valid = 1; alu_addr = 4'd5; alu_data = 32'h56;
    step();
    alu_valid = 0;
    step();
    checks++; if (pending !== 16'h0) begin failures++; $display("FAIL stall_cleanup got %h exp 0", pending); end
  endtask

  task automatic test_round_robin();
    do_issue(4'd1);
    do_issue(4'd2);
    alu_valid = 1; alu_addr = 4'd1; alu_data = 32'h11;
    mem_valid = 1; mem_addr = 4'd2; mem_data = 32'h22;
    step();
    alu_valid = 0; mem_valid = 0;
    // An issue to r6 shares the edge with the pop of r2.
    issue_valid = 1; issue_dest = 4'd6;
    step();
    issue_valid = 0;
    checks++; if ({write, write_back_address, data_write} !== {1'b1, 4'd2, 32'h22}) begin
      failures++; $display("FAIL rr1_mem_first got w=%b a=%h d=%h exp w=1 a=2 d=22", write, write_back_address, data_write); end
    checks++; if (pending !== 16'h0042) begin failures++; $display("FAIL rr1_issue_and_pop got %h exp 0042", pending); end
    step();
    checks++; if ({write, write_back_address, data_write} !== {1'b1, 4'd1, 32'h11}) begin
      failures++; $display("FAIL rr1_alu_second got w=%b a=%h d=%h exp w=1 a=1 d=11", write, write_back_address, data_write); end
    step();
    checks++; if (write !== 1'b0) begin failures++; $display("FAIL rr1_idle got %b exp 0", write); end
    do_issue(4'd3);
    do_issue(4'd4);
    alu_valid = 1; alu_addr = 4'd3; alu_data = 32'h33;
    mem_valid = 1; mem_addr = 4'd4; mem_data = 32'h44;
    step();
    alu_valid = 0; mem_valid = 0;
    step();
    checks++; if ({write, write_back_address, data_write} !== {1'b1, 4'd3, 32'h33}) begin
      failures++; $display("FAIL rr2_alu_first got w=%b a=%h d=%h exp w=1 a=3 d=33", write, write_back_address, data_write); end
    step();
    checks++; if ({write, write_back_address, data_write} !== {1'b1, 4'd4, 32'h44}) begin
      failures++; $display("FAIL rr2_mem_second got w=%b a=%h d=%h exp w=1 a=4 d=44", write, write_back_address, data_write); end
    alu_valid = 1; alu_addr = 4'd6; alu_data = 32'h66;
    step();
    alu_valid = 0;
    step();
    checks++; if ({write, write_back_address, pending} !== {1'b1, 4'd6, 16'h0}) begin
      failures++; $display("FAIL rr_clear_r6 got w=%b a=%h p=%h exp w=1 a=6 p=0", write, write_back_address, pending); end
  endtask

  task automatic test_fifo_fill();
    logic [ADDR_W+DATA_W-1:0] mexp_q[$];
    logic [ADDR_W+DATA_W-1:0] aexp_q[$];
    logic [ADDR_W+DATA_W-1:0] got, exp;
    int mi = 0;
    int ai = 0;
    int nwrites = 0;
    logic saw_full = 1'b0;
    logic m_acc, a_acc;
    for (int r = 0; r < 16; r++) do_issue(4'(r));
    checks++; if (pending !== 16'hFFFF) begin failures++; $display("FAIL fill_all_pending got %h exp ffff", pending); end
    // Loads target r0..r7, ALU results r8..r15; both sources offer every cycle.
    for (int cyc = 0; cyc < 60; cyc++) begin
      mem_valid = (mi < 8); mem_addr = 4'(mi);     mem_data = 32'hA000_0000 + 32'(mi);
      alu_valid = (ai < 8); alu_addr = 4'(8 + ai); alu_data = 32'hB000_0000 + 32'(ai);
      #1;
      m_acc = mem_valid && mem_ready;
      a_acc = alu_valid && alu_ready;
      if (mem_valid && !mem_ready) saw_full = 1'b1;
      step();
      if (m_acc) begin mexp_q.push_back({mem_addr, mem_data}); mi++; end
      if (a_acc) begin aexp_q.push_back({alu_addr, alu_data}); ai++; end
      if (write) begin
        nwrites++;
        got = {write_back_address, data_write};
        checks++;
        if (write_back_address[3] == 1'b0) begin
          if (mexp_q.size() == 0) begin failures++; $display("FAIL fill_mem_order got %h exp none", got); end
          else begin
            exp = mexp_q.pop_front();
            if (got !== exp) begin failures++; $display("FAIL fill_mem_order got %h exp %h", got, exp); end
          end
        end else begin
          if (aexp_q.size() == 0) begin failures++; $display("FAIL fill_alu_order got %h exp none", got); end
          else begin
            exp = aexp_q.pop_front();
            if (got !== exp) begin failures++; $display("FAIL fill_alu_order got %h exp %h", got, exp); end
          end
        end
      end
    end
    mem_valid = 0; alu_valid = 0;
    checks++; if (saw_full !== 1'b1) begin failures++; $display("FAIL fill_mem_ready_low got %b exp 1", saw_full); end
    checks++; if (nwrites != 16) begin failures++; $display("FAIL fill_write_count got %0d exp 16", nwrites); end
    checks++; if (mexp_q.size() + aexp_q.size() != 0) begin
      failures++; $display("FAIL fill_leftover got %0d exp 0", mexp_q.size() + aexp_q.size()); end
    checks++; if ({pending, err_spurious} !== {16'h0, 1'b0}) begin
      failures++; $display("FAIL fill_final got p=%h e=%b exp p=0 e=0", pending, err_spurious); end
  endtask

  task automatic test_spurious();
    alu_valid = 1; alu_addr = 4'd7; alu_data = 32'h77;
    step();
    alu_valid = 0;
    step();
    checks++; if ({write, write_back_address, data_write} !== {1'b1, 4'd7, 32'h77}) begin
      failures++; $display("FAIL spur_write got w=%b a=%h d=%h exp w=1 a=7 d=77", write, write_back_address, data_write); end
    checks++; if (err_spurious !== 1'b1) begin failures++; $display("FAIL spur_err_set got %b exp 1", err_spurious); end
    step(); step(); step();
    checks++; if ({write, err_spurious} !== 2'b01) begin
      failures++; $display("FAIL spur_err_sticky got w=%b e=%b exp w=0 e=1", write, err_spurious); end
  endtask

  task automatic test_reset_midstream();
    do_issue(4'd1); do_issue(4'd2); do_issue(4'd3);
    alu_valid = 1; alu_addr = 4'd1; alu_data = 32'hA1;
    mem_valid = 1; mem_addr = 4'd2; mem_data = 32'hB2;
    step();
    mem_valid = 0; alu_addr = 4'd3; alu_data = 32'hA3;
    step();
    alu_valid = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if ({write, pending} !== {1'b0, 16'h0}) begin
      failures++; $display("FAIL rstmid_state got w=%b p=%h exp w=0 p=0", write, pending); end
    checks++; if ({alu_ready, mem_ready, err_spurious} !== 3'b110) begin
      failures++; $display("FAIL rstmid_flags got %b exp 110", {alu_ready, mem_ready, err_spurious}); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (write !== 1'b0) begin failures++; $display("FAIL rstmid_no_write cycle %0d got %b exp 0", i, write); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_round_robin();
    test_fifo_fill();
    test_spurious();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
